// File: rtl/fp_sum_sequencer.sv
// rtl/fp_sum_sequencer.sv - streaming packet reduction around an external combinational FP adder
// Left-folds a packet of IEEE-754 singles into one sum, reporting element count and sticky flags.
module fp_sum_sequencer #(
  parameter int CNT_W = 16,
  parameter bit FTZ   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_special,
  output logic             out_cnt_ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [31:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_special;
  logic             r_ovf;
  logic [31:0]      r_out_data;
  logic [CNT_W-1:0] r_out_count;
  logic             r_out_special;
  logic             r_out_ovf;

  logic [31:0]      w_d;
  logic             w_accept;
  logic             w_first;
  logic             w_cnt_full;
  logic [31:0]      w_acc_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_special_nx;
  logic             w_ovf_nx;

  assign w_d = (FTZ && in_data[30:23] == 8'h00) ? {in_data[31], 31'h0} : in_data;

  assign add_a    = r_acc;
  assign add_b    = w_d;
  assign in_ready = (r_state != S_DONE);
  assign w_accept = in_valid && in_ready;
  assign w_first  = (r_state == S_IDLE);

  // The first element bypasses the adder so a lone -0.0 keeps its sign.
  assign w_cnt_full   = &r_cnt;
  assign w_acc_nx     = w_first ? w_d : add_res;
  assign w_cnt_nx     = w_first ? CNT_W'(1) : (w_cnt_full ? r_cnt : r_cnt + CNT_W'(1));
  assign w_ovf_nx     = w_first ? 1'b0 : (r_ovf | w_cnt_full);
  assign w_special_nx = (w_first ? 1'b0 : r_special) | (w_d[30:23] == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= 32'h0;
      r_cnt     <= '0;
      r_special <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_accept) begin
            r_acc     <= w_acc_nx;
            r_cnt     <= w_cnt_nx;
            r_special <= w_special_nx;
            r_ovf     <= w_ovf_nx;
            r_state   <= in_last ? S_DONE : S_ACC;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_acc     <= 32'h0;
            r_cnt     <= '0;
            r_special <= 1'b0;
            r_ovf     <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result fields are captured on the last element and held until the next packet completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data    <= 32'h0;
      r_out_count   <= '0;
      r_out_special <= 1'b0;
      r_out_ovf     <= 1'b0;
    end else if (w_accept && in_last) begin
      r_out_data    <= w_acc_nx;
      r_out_count   <= w_cnt_nx;
      r_out_special <= w_special_nx;
      r_out_ovf     <= w_ovf_nx;
    end
  end

  assign out_valid   = (r_state == S_DONE);
  assign out_data    = r_out_data;
  assign out_count   = r_out_count;
  assign out_special = r_out_special;
  assign out_cnt_ovf = r_out_ovf;

endmodule

// File: tb/tb_fp_sum_sequencer.sv
// tb/tb_fp_sum_sequencer.sv - self-checking bench for fp_sum_sequencer
// Three instances share stimulus: default, FTZ=0, and CNT_W=2 for count saturation.
module tb_fp_sum_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_last, out_ready;
  logic [31:0] in_data;

  logic        ir_a, ov_a, sp_a, of_a;
  logic [31:0] aa_a, ab_a, ar_a, od_a;
  logic [15:0] oc_a;
  logic        ir_b, ov_b, sp_b, of_b;
  logic [31:0] aa_b, ab_b, ar_b, od_b;
  logic [15:0] oc_b;
  logic        ir_c, ov_c, sp_c, of_c;
  logic [31:0] aa_c, ab_c, ar_c, od_c;
  logic [1:0]  oc_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    int  e;
    real m;
    e = int'(f[30:23]);
    if (e == 0) m = real'(f[22:0]) * (2.0 ** (-149));
    else        m = real'({1'b1, f[22:0]}) * (2.0 ** (e - 150));
    return f[31] ? -m : m;
  endfunction

  // Round-to-nearest-even from double; results below the normal range flush to zero.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    int          fe;
    d = $realtobits(r);
    if (d[62:52] == 11'h0) return {d[63], 31'h0};
    fe = int'(d[62:52]) - 1023 + 127;
    if (fe <= 0) return {d[63], 31'h0};
    m = {2'b01, d[51:29]};
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m  = m >> 1;
      fe = fe + 1;
    end
    if (fe >= 255) return {d[63], 8'hFF, 23'h0};
    return {d[63], fe[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == 8'hFF) return a;
    return r2f(f2r(a) + f2r(b));
  endfunction

  assign ar_a = f_add(aa_a, ab_a);
  assign ar_b = f_add(aa_b, ab_b);
  assign ar_c = f_add(aa_c, ab_c);

  fp_sum_sequencer #(.CNT_W(16), .FTZ(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .in_data(in_data),
    .in_last(in_last), .add_a(aa_a), .add_b(ab_a), .add_res(ar_a), .out_valid(ov_a),
    .out_ready(out_ready), .out_data(od_a), .out_count(oc_a), .out_special(sp_a), .out_cnt_ovf(of_a));
  fp_sum_sequencer #(.CNT_W(16), .FTZ(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b), .in_data(in_data),
    .in_last(in_last), .add_a(aa_b), .add_b(ab_b), .add_res(ar_b), .out_valid(ov_b),
    .out_ready(out_ready), .out_data(od_b), .out_count(oc_b), .out_special(sp_b), .out_cnt_ovf(of_b));
  fp_sum_sequencer #(.CNT_W(2), .FTZ(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_c), .in_data(in_data),
    .in_last(in_last), .add_a(aa_c), .add_b(ab_c), .add_res(ar_c), .out_valid(ov_c),
    .out_ready(out_ready), .out_data(od_c), .out_count(oc_c), .out_special(sp_c), .out_cnt_ovf(of_c));

  typedef struct packed {
    logic [4:0][31:0] xs;
    logic [2:0]       n;
    logic [31:0]      exp_data;
    logic [15:0]      exp_cnt;
    logic             exp_spec;
  } vec_t;

  vec_t        tbl[6];
  logic [31:0] pkt[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cond(input logic [31:0] x, input bit ftz);
    return (ftz && x[30:23] == 8'h00) ? {x[31], 31'h0} : x;
  endfunction

  function automatic logic [31:0] model_sum(input bit ftz);
    logic [31:0] s;
    s = cond(pkt[0], ftz);
    for (int i = 1; i < pkt.size(); i++) s = f_add(s, cond(pkt[i], ftz));
    return s;
  endfunction

  function automatic logic model_spec();
    logic sp = 1'b0;
    foreach (pkt[i]) sp |= (pkt[i][30:23] == 8'hFF);
    return sp;
  endfunction

  task automatic send(input bit gaps);
    for (int i = 0; i < pkt.size(); i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == pkt.size() - 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] ed, input int ecnt, input logic esp,
                            input logic [31:0] ebd, input bit chk_b, input int ccnt, input logic covf);
    chk({tag, ":valid"}, ov_a, 1'b1);
    chk({tag, ":in_ready"}, ir_a, 1'b0);
    chk({tag, ":data"}, od_a, ed);
    chk({tag, ":count"}, oc_a, ecnt);
    chk({tag, ":special"}, sp_a, esp);
    chk({tag, ":ovf"}, of_a, 1'b0);
    if (chk_b) chk({tag, ":data_noftz"}, od_b, ebd);
    chk({tag, ":count_sat"}, oc_c, ccnt);
    chk({tag, ":ovf_sat"}, of_c, covf);
  endtask

  task automatic collect(input string tag, input int dly, input logic [31:0] ed, input int ecnt,
                         input logic esp, input logic [31:0] ebd, input bit chk_b);
    int w = 0;
    int ccnt = (ecnt > 3) ? 3 : ecnt;
    logic covf = (ecnt > 3);
    while (!ov_a && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk({tag, ":latency"}, w, 0);
    check_outs(tag, ed, ecnt, esp, ebd, chk_b, ccnt, covf);
    out_ready = 1'b0;
    for (int k = 0; k < dly; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      in_last  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_outs({tag, ":stall"}, ed, ecnt, esp, ebd, chk_b, ccnt, covf);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ":valid_drop"}, ov_a, 1'b0);
    chk({tag, ":ready_back"}, ir_a, 1'b1);
    chk({tag, ":hold_data"}, od_a, ed);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:in_ready", ir_a, 1'b1);
    chk("rst:out_valid", ov_a, 1'b0);
    chk("rst:outs", {od_a, oc_a, sp_a, of_a}, 50'h0);
    chk("rst:acc", aa_a, 32'h0);
    rst_n = 1'b1;

    tbl[0] = '{xs: {32'h0, 32'h0, 32'h40400000, 32'h40000000, 32'h3F800000}, n: 3,
               exp_data: 32'h40C00000, exp_cnt: 3, exp_spec: 1'b0};
    tbl[1] = '{xs: {32'h0, 32'h0, 32'h0, 32'h0, 32'hC0490FDB}, n: 1,
               exp_data: 32'hC0490FDB, exp_cnt: 1, exp_spec: 1'b0};
    tbl[2] = '{xs: {32'h0, 32'h0, 32'h0, 32'h0, 32'h80000000}, n: 1,
               exp_data: 32'h80000000, exp_cnt: 1, exp_spec: 1'b0};
    tbl[3] = '{xs: {32'h0, 32'h0, 32'h0, 32'h3F800000, 32'h00000001}, n: 2,
               exp_data: 32'h3F800000, exp_cnt: 2, exp_spec: 1'b0};
    tbl[4] = '{xs: {32'h0, 32'h0, 32'h0, 32'h7F800000, 32'h3F800000}, n: 2,
               exp_data: 32'h7F800000, exp_cnt: 2, exp_spec: 1'b1};
    tbl[5] = '{xs: {32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, n: 5,
               exp_data: 32'h0, exp_cnt: 5, exp_spec: 1'b0};
    for (int v = 0; v < 6; v++) begin
      pkt.delete();
      for (int i = 0; i < int'(tbl[v].n); i++) pkt.push_back(tbl[v].xs[i]);
      send(1'b0);
      collect($sformatf("vec%0d", v), 0, tbl[v].exp_data, int'(tbl[v].exp_cnt), tbl[v].exp_spec,
              32'h0, 1'b0);
    end

    pkt = '{32'h3F800000, 32'h40000000, 32'h40400000};
    send(1'b0);
    collect("backpressure", 5, 32'h40C00000, 3, 1'b0, 32'h40C00000, 1'b1);

    in_data = 32'h00000001;
    #1;
    chk("ftz:add_b", ab_a, 32'h0);
    chk("noftz:add_b", ab_b, 32'h00000001);

    in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b0;
    @(posedge clk);
    #1;
    in_data = 32'h40000000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("midrst:acc_before", aa_a, 32'h40400000);
    rst_n = 1'b0;
    #1;
    chk("midrst:in_ready", ir_a, 1'b1);
    chk("midrst:out_valid", ov_a, 1'b0);
    chk("midrst:outs", {od_a, oc_a, sp_a, of_a}, 50'h0);
    chk("midrst:acc", aa_a, 32'h0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pkt = '{32'h40000000};
    send(1'b0);
    collect("after_rst", 0, 32'h40000000, 1, 1'b0, 32'h40000000, 1'b1);

    for (int p = 0; p < 40; p++) begin
      int n = $urandom_range(1, 8);
      pkt.delete();
      for (int i = 0; i < n; i++) begin
        int sel = $urandom_range(0, 19);
        logic [31:0] x = $urandom;
        if (sel == 0)      x[30:23] = 8'h00;
        else if (sel == 1) x[30:23] = 8'hFF;
        else               x[30:23] = 8'($urandom_range(110, 140));
        pkt.push_back(x);
      end
      send(1'b1);
      collect($sformatf("rnd%0d", p), $urandom_range(0, 3), model_sum(1'b1), n, model_spec(),
              model_sum(1'b0), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_sum_sequencer.md
Name: fp_sum_sequencer

Overview:
- Streaming reduction controller wrapped around the combinational single-precision adder (`mainmodule`).
- Accepts a packet of IEEE-754 single-precision values over a valid/ready stream.
- Feeds the running sum and each new element to the adder as operands, and registers the adder's result each cycle.
- Presents the final packet sum, element count and status flags on an output valid/ready stream.

Parameters:
- CNT_W, 16, width of the element counter `out_count`.
- FTZ, 1, when 1 an input with exponent 8'h00 is replaced by a zero of the same sign before use.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input element valid.
- in_ready  output  1  sequencer can accept an element.
- in_data  input  32  input element, IEEE-754 single.
- in_last  input  1  marks the final element of the packet.
- add_a  output  32  adder operand a (running sum); combinational.
- add_b  output  32  adder operand b (conditioned in_data); combinational.
- add_res  input  32  adder result; combinational function of add_a and add_b in the same cycle.
- out_valid  output  1  packet result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  packet sum.
- out_count  output  CNT_W  number of elements accepted in the packet, saturating.
- out_special  output  1  sticky: some element had exponent 8'hFF.
- out_cnt_ovf  output  1  sticky: the element count saturated.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - state IDLE, acc=32'h0, cnt=0, special=0, ovf=0;
  - in_ready=1, out_valid=0, out_data=0, out_count=0, out_special=0, out_cnt_ovf=0.
- Reset asserted mid-packet discards the partial sum. No output is produced for that packet.
- Conditioning: d = (FTZ && in_data[30:23]==8'h00) ? {in_data[31],31'h0} : in_data.
- Operand drive: add_a=acc and add_b=d at all times. Both are purely combinational; the adder sees no register stage.
- Accept: an element is accepted when in_valid && in_ready on a rising edge.
- in_ready is 1 in IDLE and ACC, and 0 in DONE.
- States:
  - IDLE (no element yet). On accept: acc<=d (adder bypassed, so a single -0.0 stays -0.0), cnt<=1, special<=(d[30:23]==8'hFF). Go to DONE if in_last, else ACC.
  - ACC. On accept: acc<=add_res, cnt<=cnt+1 saturating at all-ones, with ovf set when an increment is attempted at all-ones. special |= (d[30:23]==8'hFF). Go to DONE if in_last, else stay in ACC. With no accept, hold all state.
  - DONE. out_valid=1; out_data=acc, out_count=cnt, out_special=special, out_cnt_ovf=ovf, all held stable while out_ready=0. On out_valid && out_ready: return to IDLE next cycle, clear acc/cnt/special/ovf, out_valid drops.
- Output fields are registered and remain at their last values outside DONE. out_valid is the only qualifier.
- Throughput: one element per cycle in IDLE/ACC. Latency from the accepted in_last to out_valid=1 is one cycle.
- Packet turnaround: DONE plus one IDLE-entry cycle, with no overlap. in_ready=0 in DONE, so simultaneous input and output handshakes cannot occur.
- in_data and in_last are ignored whenever in_ready=0. in_valid may drop between elements without effect.
- No rounding or normalisation is done here. Arithmetic and rounding are solely the adder's; out_data equals the left-fold acc=add(acc,x_i).
- NaN and Inf are not interpreted. They are only flagged via special and passed through the adder unchanged.

Test Plan:
- Sum: packet {3F800000, 40000000, 40400000 (last)}, back-to-back, out_ready=1 → one cycle after last: out_valid=1, out_data=40C00000, out_count=3, flags 0; IDLE the following cycle.
- Single element: {C0490FDB (last)} → out_data=C0490FDB, out_count=1. Also {80000000 (last)} → out_data=80000000 (bypass preserves -0).
- Backpressure: sum packet with out_ready=0 for 5 cycles → out_valid stays 1, out_data/out_count stable, in_ready=0 and in_valid pulses are ignored; on out_ready=1 handshake completes and in_ready returns to 1.
- FTZ=1: {00000001, 3F800000 (last)} → out_data=3F800000, out_count=2. With FTZ=0, the adder sees 00000001 unmodified.
- Special and saturation: {3F800000, 7F800000 (last)} → out_special=1. CNT_W=2 packet of 5 × 00000000 → out_count=3, out_cnt_ovf=1.
- Reset mid-packet: 2 elements accepted, rst_n pulsed low → all outputs 0 and state IDLE immediately; then packet {40000000 (last)} → out_data=40000000, out_count=1.
